// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit
// Description : Instruction fetch front end for the pipelined MIPS CPU.
//               Avalon-MM read master on the instruction bus. It buffers
//               fetched words with their PCs in a small prefetch FIFO and
//               hands them to decode over a valid/ready handshake.
//               Redirects flush the FIFO and drop any stalled in-flight read.
//               Fetching stops for good once the next fetch address is 0.
// Ports       : clk, reset_n         - clock / async active-low reset
//               address, read        - bus request (word aligned)
//               waitrequest,readdata - bus slave stall / return data
//               Redirect, RedirectPC - one-cycle control-flow redirect
//               Instruction, InstrPC - FIFO head word and its fetch address
//               InstrValid,InstrReady- head handshake to decode
//               Active               - low once halted and fully drained
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        Active
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  localparam logic [1:0] c_st_start = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_halt  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_next;
  logic [31:0]     r_req_addr;    // address of the read currently stalled
  logic            r_busy;        // a read was stalled last cycle and must hold
  logic            r_discard;     // the outstanding read belongs to a stale path

  logic [c_cw-1:0] r_count;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [31:0]     r_mem_data [DEPTH];
  logic [31:0]     r_mem_pc   [DEPTH];

  logic            w_complete;
  logic            w_stall;
  logic            w_redirect;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_redirect_pc;
  logic            w_unused_ok;

  assign w_redirect_pc = {RedirectPC[31:2], 2'b00};
  assign w_unused_ok   = ^RedirectPC[1:0];

  assign w_complete = read & ~waitrequest;
  assign w_stall    = read & waitrequest;
  // Redirect only matters while fetching; START and HALT ignore it.
  assign w_redirect = Redirect & (r_state == c_st_fetch);
  // A redirect wins over any same-cycle push or pop: the FIFO is emptied.
  assign w_push     = w_complete & ~r_discard & ~w_redirect;
  assign w_pop      = InstrValid & InstrReady & ~w_redirect;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
    if (!reset_n) begin
      r_state <= c_st_start;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin : p_next_state
    w_state_next = r_state;
    case (r_state)
      c_st_start: w_state_next = c_st_fetch;
      c_st_fetch: begin
        if (w_fetch_pc_next == 32'd0) begin
          w_state_next = c_st_halt;
        end
      end
      c_st_halt:  w_state_next = c_st_halt;
      default:    w_state_next = c_st_start;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin : p_outputs
    // A stalled read keeps read/address frozen until it completes, in any
    // state; a new read is only issued in FETCH when the FIFO has room.
    read        = r_busy | ((r_state == c_st_fetch) && (r_count < c_depth));
    address     = r_busy ? r_req_addr : r_fetch_pc;
    InstrValid  = (r_count != '0);
    Active      = ~((r_state == c_st_halt) && (r_count == '0) && ~r_busy);
    Instruction = r_mem_data[r_rd_ptr];
    InstrPC     = r_mem_pc[r_rd_ptr];
  end

  // --------------------------------------------------------------------------
  // Fetch PC: redirect target, or next sequential word after a kept read
  // --------------------------------------------------------------------------
  always_comb begin : p_fetch_pc_next
    w_fetch_pc_next = r_fetch_pc;
    if (w_redirect) begin
      w_fetch_pc_next = w_redirect_pc;
    end else if (w_push && (r_state == c_st_fetch)) begin
      w_fetch_pc_next = r_fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_bus_track
    if (!reset_n) begin
      r_fetch_pc <= RESET_VECTOR;
      r_req_addr <= RESET_VECTOR;
      r_busy     <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= address;
      r_busy     <= w_stall;
      // Only a read still stalled at the redirect can return stale data;
      // one completing in the redirect cycle is simply not pushed.
      if (w_redirect) begin
        r_discard <= w_stall;
      end else if (w_complete) begin
        r_discard <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin : p_fifo
    if (!reset_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= readdata;
        r_mem_pc[r_wr_ptr]   <= address;
        r_wr_ptr             <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cw'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_cw'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_unit
// Description : Self-checking bench for mips_fetch_unit. A queue-based
//               reference model tracks the fetch PC, the buffered words and
//               the outstanding bus read; directed scenarios are followed by
//               a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam logic [31:0] PAT   = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Active;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .RESET_VECTOR(RV),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .read       (read),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Instruction(Instruction),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Active     (Active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program-order view of the fetch front end.
  bit          m_started;
  bit          m_halted;
  bit          m_busy;
  bit          m_discard;
  logic [31:0] m_pc;
  logic [31:0] m_busy_addr;
  logic [63:0] m_q[$];     // {pc, word} in delivery order

  task automatic model_reset();
    m_started   = 1'b0;
    m_halted    = 1'b0;
    m_busy      = 1'b0;
    m_discard   = 1'b0;
    m_pc        = RV;
    m_busy_addr = RV;
    m_q.delete();
  endtask

  // Entered shortly after a rising edge; leaves 1 time unit after a rising edge.
  task automatic do_reset();
    #1 reset_n = 1'b0;
    #1;
    check("rst_read",        32'(read),       32'd0);
    check("rst_valid",       32'(InstrValid), 32'd0);
    check("rst_active",      32'(Active),     32'd1);
    check("rst_address",     address,         RV);
    check("rst_instruction", Instruction,     32'd0);
    check("rst_instrpc",     InstrPC,         32'd0);
    model_reset();
    waitrequest = 1'b0;
    Redirect    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cycle(input bit wr, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          e_read, e_valid, e_active, complete, stall, redir, pop;
    logic [31:0] e_addr;
    logic [63:0] head;
    e_read   = m_busy || (m_started && !m_halted && (m_q.size() < DEPTH));
    e_addr   = m_busy ? m_busy_addr : m_pc;
    e_valid  = (m_q.size() != 0);
    e_active = !(m_halted && (m_q.size() == 0) && !m_busy);
    head     = e_valid ? m_q[0] : 64'd0;

    waitrequest = wr;
    Redirect    = rd;
    RedirectPC  = rpc;
    InstrReady  = rdy;
    readdata    = e_addr ^ PAT;

    @(negedge clk);
    check("read", 32'(read), 32'(e_read));
    if (e_read) check("address", address, e_addr);
    check("instr_valid", 32'(InstrValid), 32'(e_valid));
    if (e_valid) begin
      check("instr_pc",    InstrPC,     head[63:32]);
      check("instruction", Instruction, head[31:0]);
    end
    check("active", 32'(Active), 32'(e_active));

    complete = e_read && !wr;
    stall    = e_read && wr;
    redir    = rd && m_started && !m_halted;
    pop      = e_valid && rdy && !redir;

    @(posedge clk);
    #1;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (redir) begin
      m_q.delete();
      m_pc      = {rpc[31:2], 2'b00};
      m_discard = stall;
      if (m_pc == 32'd0) m_halted = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (complete) begin
        if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          m_q.push_back({e_addr, e_addr ^ PAT});
          if (!m_halted) begin
            m_pc = m_pc + 32'd4;
            if (m_pc == 32'd0) m_halted = 1'b1;
          end
        end
      end
    end
    m_busy      = stall;
    m_busy_addr = e_addr;
  endtask

  initial begin
    waitrequest = 1'b0;
    Redirect    = 1'b0;
    RedirectPC  = 32'd0;
    InstrReady  = 1'b1;
    readdata    = 32'd0;
    model_reset();
    #1;

    // Sustained streaming from the reset vector
    do_reset();
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // First read stalled for three cycles
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Back-pressure: FIFO fills, then resumes
    repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect while the read of BFC00008 is stalled
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h00400013, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit          wr, rd, rdy;
      logic [31:0] tgt;
      wr  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = $urandom() | 32'h0000_1000;
      tgt[31] = 1'b0;
      cycle(wr, rd, tgt, rdy);
    end

    // Sequential wrap to 0: last words drain, then halt; redirect ignored
    cycle(1'b0, 1'b1, 32'hFFFFFFF0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    check("wrap_halted_active", 32'(Active), 32'd0);
    repeat (3) cycle(1'b0, 1'b1, 32'h00000100, 1'b1);
    check("wrap_redirect_ignored", 32'(read), 32'd0);

    // Redirect to 0 with a stalled read outstanding
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 32'h00000100, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Reset pulsed in the middle of a stall
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    waitrequest = 1'b1;
    do_reset();
    repeat (8) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch front end for the pipelined MIPS CPU. Acts as Avalon-MM read master on the instruction bus, buffers fetched words in a small prefetch FIFO, and presents them with their PCs to the decode/verify stage over a valid/ready handshake. Handles control-flow redirects by flushing the FIFO and discarding any in-flight read. Implements the coursework halt convention: execution stops when the next fetch address is 0.

## Interface
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  out  32  instruction bus word address; [1:0] always 00
- read  out  1  bus read request
- waitrequest  in  1  slave stall; read completes in the cycle read=1 & waitrequest=0
- readdata  in  32  read data, valid in the completion cycle
- Redirect  in  1  one-cycle pulse: flush and fetch from RedirectPC
- RedirectPC  in  32  redirect target; [1:0] ignored
- Instruction  out  32  FIFO head instruction word
- InstrPC  out  32  address the head word was fetched from
- InstrValid  out  1  head entry valid
- InstrReady  in  1  consumer accepts head when InstrValid=1
- Active  out  1  high until halted and drained

## Operation
- States: START (reset), FETCH, HALT.
- START → FETCH unconditionally on the first edge after reset_n deasserts; read=0 in START.
- FETCH: read=1 when FIFO count + pending < DEPTH; address = FetchPC. One outstanding read at most.
- Avalon rule: once read=1 with waitrequest=1, read and address hold stable until completion, regardless of Redirect.
- Completion (read & !waitrequest): if Discard=0, push {readdata, address} and FetchPC += 4 (mod 2^32); if Discard=1, drop data, clear Discard, no push.
- Pop when InstrValid & InstrReady; push and pop in the same cycle are both honoured.
- Redirect in FETCH: FIFO flushed (count=0), FetchPC ← {RedirectPC[31:2],2'b00}; if a read is stalled that cycle, Discard ← 1. Redirect overrides same-cycle push and pop.
- Halt: when FetchPC becomes 0 (redirect to 0 or sequential wrap from 32'hFFFFFFFC), go to HALT; no further reads issued (a stalled read still completes and is discarded if redirect-caused, pushed if sequential).
- HALT: Redirect ignored; FIFO continues to drain. Active ← 0 once FIFO empty and no read outstanding. Only reset leaves HALT.
- Instruction/InstrPC read the FIFO head; hold value while InstrValid=1 & InstrReady=0.

## Timing
- Reset values: state START, read 0, address RESET_VECTOR, InstrValid 0, Instruction 0, InstrPC 0, Active 1, Discard 0, count 0.
- reset_n asserted mid-transaction: all state cleared immediately (asynchronous); read drops in the same cycle.
- First read asserted the cycle after the first post-reset edge.
- Completion at edge N → InstrValid=1 after edge N (1-cycle latency).
- With waitrequest=0 and InstrReady=1: one instruction per cycle sustained.
- Redirect at edge N: InstrValid=0 after edge N; first read to target in cycle N+1 (or after pending discarded read completes).
- FIFO full: read=0 until a pop; read reasserts the cycle after the pop edge.

## Test plan
- Reset, waitrequest=0, readdata=address^32'h5A5A5A5A, InstrReady=1 → InstrPC sequence BFC00000, BFC00004, BFC00008 on consecutive cycles with matching Instruction.
- waitrequest high 3 cycles on first read → read and address BFC00000 stable all 3 cycles; single push; InstrValid one cycle after completion.
- InstrReady=0 → exactly DEPTH words buffered, read=0, head holds BFC00000; InstrReady=1 resumes with no lost or duplicated PCs.
- Redirect to 32'h00400013 while read of BFC00008 stalled → FIFO flushed, stalled data discarded, next pushed InstrPC = 32'h00400010.
- Redirect to 0 → no further reads, remaining FIFO entries drain, Active falls once empty; later Redirect to 32'h100 ignored.
- reset_n pulsed low mid-stall → read=0 immediately, InstrValid=0, restart from BFC00000.
